pe_memc_port_arbiter: RTL and testbench



---
 rtl/pe_memc_arb_pkg.sv | 30 +++
 rtl/pe_memc_rr_arbiter.sv | 30 +++
 rtl/pe_memc_port_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_pe_memc_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_memc_arb_pkg.sv
// Shared types and default constants for the PE memory-port arbiter.
package pe_memc_arb_pkg;

    localparam int DEF_NUM_DMA    = 2;
    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_RD_LAT = 2;

    // DMA index width inside a source tag; sized for the default channel count.
    localparam int DMA_IDX_W = (DEF_NUM_DMA > 1) ? $clog2(DEF_NUM_DMA) : 1;

    typedef enum logic [1:0] {
        DMA_MODE = 2'd0,
        DRAIN    = 2'd1,
        LDST_OWN = 2'd2
    } memc_arb_state_e;

    // Requester that issued an access: the ldst flag wins over the DMA index.
    typedef struct packed {
        logic                 ldst;
        logic [DMA_IDX_W-1:0] idx;
    } memc_src_t;

    // One entry of the read-return tag pipe.
    typedef struct packed {
        logic      valid;
        memc_src_t src;
    } rd_tag_t;

endpackage

// File: rtl/pe_memc_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module pe_memc_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   next_ptr
);

    // Scan requesters starting at ptr; the pointer moves past the winner.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/pe_memc_port_arbiter.sv
// Arbitrates one PE SRAM port between the load/store unit and DMA channels.
module pe_memc_port_arbiter
    import pe_memc_arb_pkg::*;
#(
    parameter int NUM_DMA    = DEF_NUM_DMA,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_RD_LAT = DEF_MEM_RD_LAT
) (
    input  logic                             clk,
    input  logic                             reset_poweron,

    input  logic                             ldst__memc__request,
    output logic                             memc__ldst__granted,
    input  logic                             ldst__memc__released,
    input  logic                             ldst__memc__write_valid,
    input  logic [ADDR_W-1:0]                ldst__memc__write_address,
    input  logic [DATA_W-1:0]                ldst__memc__write_data,
    input  logic                             ldst__memc__read_valid,
    input  logic [ADDR_W-1:0]                ldst__memc__read_address,
    output logic                             memc__ldst__read_data_valid,
    output logic [DATA_W-1:0]                memc__ldst__read_data,

    input  logic [NUM_DMA-1:0]               dma__memc__write_valid,
    input  logic [NUM_DMA-1:0][ADDR_W-1:0]   dma__memc__write_address,
    input  logic [NUM_DMA-1:0][DATA_W-1:0]   dma__memc__write_data,
    output logic [NUM_DMA-1:0]               memc__dma__write_ready,
    input  logic [NUM_DMA-1:0]               dma__memc__read_valid,
    input  logic [NUM_DMA-1:0][ADDR_W-1:0]   dma__memc__read_address,
    output logic [NUM_DMA-1:0]               memc__dma__read_ready,
    output logic [NUM_DMA-1:0]               memc__dma__read_data_valid,
    output logic [NUM_DMA-1:0][DATA_W-1:0]   memc__dma__read_data,

    output logic                             memc__mem__en,
    output logic                             memc__mem__we,
    output logic [ADDR_W-1:0]                memc__mem__addr,
    output logic [DATA_W-1:0]                memc__mem__wdata,
    input  logic [DATA_W-1:0]                mem__memc__rdata
);

    localparam int RR_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

    memc_arb_state_e     state_q;
    logic [RR_W-1:0]     rr_q;
    logic [RR_W-1:0]     rr_next;
    logic [NUM_DMA-1:0]  rr_grant;
    logic                rr_advance;
    logic                pipe_busy;

    logic                acc_en;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    memc_src_t           acc_src;

    rd_tag_t             tag_q [MEM_RD_LAT+1];

    pe_memc_rr_arbiter #(
        .NUM_REQ (NUM_DMA),
        .PTR_W   (RR_W)
    ) u_rr (
        .req      (dma__memc__write_valid | dma__memc__read_valid),
        .ptr      (rr_q),
        .grant    (rr_grant),
        .next_ptr (rr_next)
    );

    // Pick this cycle's access: a DMA winner in DMA_MODE, or the ldst unit while it owns the port.
    always_comb begin
        memc__dma__write_ready = '0;
        memc__dma__read_ready  = '0;
        acc_en     = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = '0;
        acc_wdata  = '0;
        acc_src    = '0;
        rr_advance = 1'b0;
        if (!reset_poweron) begin
            case (state_q)
                DMA_MODE: begin
                    if (!ldst__memc__request) begin
                        for (int i = 0; i < NUM_DMA; i++) begin
                            if (rr_grant[i]) begin
                                acc_en      = 1'b1;
                                rr_advance  = 1'b1;
                                acc_src.idx = DMA_IDX_W'(i);
                                if (dma__memc__write_valid[i]) begin
                                    memc__dma__write_ready[i] = 1'b1;
                                    acc_we    = 1'b1;
                                    acc_addr  = dma__memc__write_address[i];
                                    acc_wdata = dma__memc__write_data[i];
                                end else begin
                                    memc__dma__read_ready[i] = 1'b1;
                                    acc_addr = dma__memc__read_address[i];
                                end
                            end
                        end
                    end
                end
                LDST_OWN: begin
                    acc_src.ldst = 1'b1;
                    if (ldst__memc__write_valid) begin
                        acc_en    = 1'b1;
                        acc_we    = 1'b1;
                        acc_addr  = ldst__memc__write_address;
                        acc_wdata = ldst__memc__write_data;
                    end else if (ldst__memc__read_valid) begin
                        acc_en   = 1'b1;
                        acc_addr = ldst__memc__read_address;
                    end
                end
                default: ;
            endcase
        end
    end

    // The pipe counts as drained when only the retiring stage (if any) still holds a read.
    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < MEM_RD_LAT; k++) begin
            pipe_busy = pipe_busy | tag_q[k].valid;
        end
    end

    // Ownership FSM with the registered grant and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q             <= DMA_MODE;
            memc__ldst__granted <= 1'b0;
            rr_q                <= '0;
        end else begin
            if (rr_advance) begin
                rr_q <= rr_next;
            end
            case (state_q)
                DMA_MODE: begin
                    if (ldst__memc__request) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state_q             <= LDST_OWN;
                        memc__ldst__granted <= 1'b1;
                    end
                end
                LDST_OWN: begin
                    if (ldst__memc__released) begin
                        state_q             <= DMA_MODE;
                        memc__ldst__granted <= 1'b0;
                    end
                end
                default: begin
                    state_q             <= DMA_MODE;
                    memc__ldst__granted <= 1'b0;
                end
            endcase
        end
    end

    // Registered memory port; address and write data hold their last values while idle.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            memc__mem__en    <= 1'b0;
            memc__mem__we    <= 1'b0;
            memc__mem__addr  <= '0;
            memc__mem__wdata <= '0;
        end else begin
            memc__mem__en <= acc_en;
            memc__mem__we <= acc_we;
            if (acc_en) begin
                memc__mem__addr <= acc_addr;
            end
            if (acc_en && acc_we) begin
                memc__mem__wdata <= acc_wdata;
            end
        end
    end

    // Tag pipe that follows each read through the memory latency to its requester.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int k = 0; k <= MEM_RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= acc_en && !acc_we;
            tag_q[0].src   <= acc_src;
            for (int k = 1; k <= MEM_RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Steer returning read data to the tagged requester; everyone else sees zero.
    always_comb begin
        memc__ldst__read_data_valid = 1'b0;
        memc__ldst__read_data       = '0;
        memc__dma__read_data_valid  = '0;
        memc__dma__read_data        = '0;
        if (tag_q[MEM_RD_LAT].valid) begin
            if (tag_q[MEM_RD_LAT].src.ldst) begin
                memc__ldst__read_data_valid = 1'b1;
                memc__ldst__read_data       = mem__memc__rdata;
            end else begin
                for (int i = 0; i < NUM_DMA; i++) begin
                    if (tag_q[MEM_RD_LAT].src.idx == DMA_IDX_W'(i)) begin
                        memc__dma__read_data_valid[i] = 1'b1;
                        memc__dma__read_data[i]       = mem__memc__rdata;
                    end
                end
            end
        end
    end

    // Both ldst valids at once means the read is silently dropped; flag it in simulation.
    ldst_dual_access : assert property (@(posedge clk) disable iff (reset_poweron)
        !(state_q == LDST_OWN && ldst__memc__write_valid && ldst__memc__read_valid))
        else $error("ldst presented write and read together; read dropped");

endmodule

// File: tb/tb_pe_memc_port_arbiter.sv
// Directed self-checking bench for the PE memory-port arbiter.
module tb_pe_memc_port_arbiter;

    localparam int NUM_DMA = 2;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;

    logic                           clk;
    logic                           reset_poweron;
    logic                           ldst__memc__request;
    logic                           memc__ldst__granted;
    logic                           ldst__memc__released;
    logic                           ldst__memc__write_valid;
    logic [ADDR_W-1:0]              ldst__memc__write_address;
    logic [DATA_W-1:0]              ldst__memc__write_data;
    logic                           ldst__memc__read_valid;
    logic [ADDR_W-1:0]              ldst__memc__read_address;
    logic                           memc__ldst__read_data_valid;
    logic [DATA_W-1:0]              memc__ldst__read_data;
    logic [NUM_DMA-1:0]             dma__memc__write_valid;
    logic [NUM_DMA-1:0][ADDR_W-1:0] dma__memc__write_address;
    logic [NUM_DMA-1:0][DATA_W-1:0] dma__memc__write_data;
    logic [NUM_DMA-1:0]             memc__dma__write_ready;
    logic [NUM_DMA-1:0]             dma__memc__read_valid;
    logic [NUM_DMA-1:0][ADDR_W-1:0] dma__memc__read_address;
    logic [NUM_DMA-1:0]             memc__dma__read_ready;
    logic [NUM_DMA-1:0]             memc__dma__read_data_valid;
    logic [NUM_DMA-1:0][DATA_W-1:0] memc__dma__read_data;
    logic                           memc__mem__en;
    logic                           memc__mem__we;
    logic [ADDR_W-1:0]              memc__mem__addr;
    logic [DATA_W-1:0]              memc__mem__wdata;
    logic [DATA_W-1:0]              mem__memc__rdata;

    int checkCount = 0;
    int failCount  = 0;

    logic [DATA_W-1:0] memArray [256];
    logic [DATA_W-1:0] rdStage1;
    logic [DATA_W-1:0] rdStage2;

    pe_memc_port_arbiter #(
        .NUM_DMA    (NUM_DMA),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_RD_LAT (2)
    ) dut (
        .clk                         (clk),
        .reset_poweron               (reset_poweron),
        .ldst__memc__request         (ldst__memc__request),
        .memc__ldst__granted         (memc__ldst__granted),
        .ldst__memc__released        (ldst__memc__released),
        .ldst__memc__write_valid     (ldst__memc__write_valid),
        .ldst__memc__write_address   (ldst__memc__write_address),
        .ldst__memc__write_data      (ldst__memc__write_data),
        .ldst__memc__read_valid      (ldst__memc__read_valid),
        .ldst__memc__read_address    (ldst__memc__read_address),
        .memc__ldst__read_data_valid (memc__ldst__read_data_valid),
        .memc__ldst__read_data       (memc__ldst__read_data),
        .dma__memc__write_valid      (dma__memc__write_valid),
        .dma__memc__write_address    (dma__memc__write_address),
        .dma__memc__write_data       (dma__memc__write_data),
        .memc__dma__write_ready      (memc__dma__write_ready),
        .dma__memc__read_valid       (dma__memc__read_valid),
        .dma__memc__read_address     (dma__memc__read_address),
        .memc__dma__read_ready       (memc__dma__read_ready),
        .memc__dma__read_data_valid  (memc__dma__read_data_valid),
        .memc__dma__read_data        (memc__dma__read_data),
        .memc__mem__en               (memc__mem__en),
        .memc__mem__we               (memc__mem__we),
        .memc__mem__addr             (memc__mem__addr),
        .memc__mem__wdata            (memc__mem__wdata),
        .mem__memc__rdata            (mem__memc__rdata)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-cycle-latency SRAM model behind the registered port.
    always @(posedge clk) begin
        if (memc__mem__en && memc__mem__we) begin
            memArray[memc__mem__addr[7:0]] <= memc__mem__wdata;
        end
        rdStage1 <= memArray[memc__mem__addr[7:0]];
        rdStage2 <= rdStage1;
    end
    assign mem__memc__rdata = rdStage2;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        ldst__memc__request       = 1'b0;
        ldst__memc__released      = 1'b0;
        ldst__memc__write_valid   = 1'b0;
        ldst__memc__write_address = '0;
        ldst__memc__write_data    = '0;
        ldst__memc__read_valid    = 1'b0;
        ldst__memc__read_address  = '0;
        dma__memc__write_valid    = '0;
        dma__memc__write_address  = '0;
        dma__memc__write_data     = '0;
        dma__memc__read_valid     = '0;
        dma__memc__read_address   = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_granted"}, 64'(memc__ldst__granted), 64'd0);
        checkOutput({tag, "_wready"},  64'(memc__dma__write_ready), 64'd0);
        checkOutput({tag, "_rready"},  64'(memc__dma__read_ready), 64'd0);
        checkOutput({tag, "_dma_rdv"}, 64'(memc__dma__read_data_valid), 64'd0);
        checkOutput({tag, "_dma_rd"},  64'(memc__dma__read_data), 64'd0);
        checkOutput({tag, "_ldst_rdv"}, 64'(memc__ldst__read_data_valid), 64'd0);
        checkOutput({tag, "_ldst_rd"}, 64'(memc__ldst__read_data), 64'd0);
        checkOutput({tag, "_mem_en"},  64'(memc__mem__en), 64'd0);
        checkOutput({tag, "_mem_we"},  64'(memc__mem__we), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(memc__mem__addr), 64'd0);
        checkOutput({tag, "_mem_wdata"}, 64'(memc__mem__wdata), 64'd0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            memArray[a] = '0;
        end
        memArray[8'h40] = 32'hDEADBEEF;
        memArray[8'h44] = 32'h12345678;
        memArray[8'h80] = 32'hCAFEF00D;
        rdStage1 = '0;
        rdStage2 = '0;

        applyStimulus();
        reset_poweron = 1'b1;
        step();
        step();
        reset_poweron = 1'b0;
        #1;
        checkAllZero("reset");

        // Round-robin between two writing channels.
        step();
        dma__memc__write_valid      = 2'b11;
        dma__memc__write_address[0] = 24'h10;
        dma__memc__write_data[0]    = 32'hA0;
        dma__memc__write_address[1] = 24'h20;
        dma__memc__write_data[1]    = 32'hB1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rr_wready", 64'(memc__dma__write_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            checkOutput("rr_rready", 64'(memc__dma__read_ready), 64'd0);
            if (k > 0) begin
                checkOutput("rr_mem_en", 64'(memc__mem__en), 64'd1);
                checkOutput("rr_mem_we", 64'(memc__mem__we), 64'd1);
                checkOutput("rr_mem_addr", 64'(memc__mem__addr), (k % 2 == 1) ? 64'h10 : 64'h20);
            end
            step();
        end
        dma__memc__write_valid = 2'b00;
        #1;
        checkOutput("rr_last_addr", 64'(memc__mem__addr), 64'h20);
        checkOutput("rr_last_wdata", 64'(memc__mem__wdata), 64'hB1);
        checkOutput("rr_idle_wready", 64'(memc__dma__write_ready), 64'd0);
        step();
        checkOutput("idle_en", 64'(memc__mem__en), 64'd0);
        checkOutput("idle_we", 64'(memc__mem__we), 64'd0);
        checkOutput("idle_addr_hold", 64'(memc__mem__addr), 64'h20);
        checkOutput("idle_wdata_hold", 64'(memc__mem__wdata), 64'hB1);

        // Channel 1 read returns three cycles after acceptance.
        dma__memc__read_valid[1]   = 1'b1;
        dma__memc__read_address[1] = 24'h40;
        #1;
        checkOutput("rd_rready", 64'(memc__dma__read_ready), 64'd2);
        step();
        dma__memc__read_valid = 2'b00;
        checkOutput("rd_mem_en", 64'(memc__mem__en), 64'd1);
        checkOutput("rd_mem_we", 64'(memc__mem__we), 64'd0);
        checkOutput("rd_mem_addr", 64'(memc__mem__addr), 64'h40);
        step();
        checkOutput("rd_early_valid", 64'(memc__dma__read_data_valid), 64'd0);
        step();
        checkOutput("rd_valid", 64'(memc__dma__read_data_valid), 64'd2);
        checkOutput("rd_data1", 64'(memc__dma__read_data[1]), 64'hDEADBEEF);
        checkOutput("rd_data0", 64'(memc__dma__read_data[0]), 64'd0);
        checkOutput("rd_ldst_valid", 64'(memc__ldst__read_data_valid), 64'd0);
        step();
        checkOutput("rd_after_valid", 64'(memc__dma__read_data_valid), 64'd0);

        // Lock request while a channel 0 read is in flight.
        dma__memc__read_valid[0]   = 1'b1;
        dma__memc__read_address[0] = 24'h44;
        #1;
        checkOutput("lk_rready_t", 64'(memc__dma__read_ready), 64'd1);
        step();
        dma__memc__read_valid       = 2'b00;
        ldst__memc__request         = 1'b1;
        dma__memc__write_valid[1]   = 1'b1;
        dma__memc__write_address[1] = 24'h20;
        dma__memc__write_data[1]    = 32'hB1;
        #1;
        checkOutput("lk_wready_t1", 64'(memc__dma__write_ready), 64'd0);
        checkOutput("lk_granted_t1", 64'(memc__ldst__granted), 64'd0);
        step();
        ldst__memc__request = 1'b0;
        #1;
        checkOutput("lk_wready_t2", 64'(memc__dma__write_ready), 64'd0);
        checkOutput("lk_granted_t2", 64'(memc__ldst__granted), 64'd0);
        step();
        checkOutput("lk_wready_t3", 64'(memc__dma__write_ready), 64'd0);
        checkOutput("lk_granted_t3", 64'(memc__ldst__granted), 64'd0);
        checkOutput("lk_rd_valid", 64'(memc__dma__read_data_valid), 64'd1);
        checkOutput("lk_rd_data0", 64'(memc__dma__read_data[0]), 64'h12345678);
        step();
        checkOutput("lk_granted_t4", 64'(memc__ldst__granted), 64'd1);
        checkOutput("lk_wready_t4", 64'(memc__dma__write_ready), 64'd0);
        checkOutput("lk_mem_en_t4", 64'(memc__mem__en), 64'd0);
        ldst__memc__write_valid   = 1'b1;
        ldst__memc__write_address = 24'h100;
        ldst__memc__write_data    = 32'h5;
        step();
        ldst__memc__write_valid = 1'b0;
        checkOutput("lk_wr_en", 64'(memc__mem__en), 64'd1);
        checkOutput("lk_wr_we", 64'(memc__mem__we), 64'd1);
        checkOutput("lk_wr_addr", 64'(memc__mem__addr), 64'h100);
        checkOutput("lk_wr_wdata", 64'(memc__mem__wdata), 64'h5);

        // Release in the same cycle as an ldst read.
        ldst__memc__read_valid   = 1'b1;
        ldst__memc__read_address = 24'h80;
        ldst__memc__released     = 1'b1;
        #1;
        checkOutput("rel_granted_n", 64'(memc__ldst__granted), 64'd1);
        checkOutput("rel_wready_n", 64'(memc__dma__write_ready), 64'd0);
        step();
        ldst__memc__read_valid = 1'b0;
        ldst__memc__released   = 1'b0;
        #1;
        checkOutput("rel_granted_n1", 64'(memc__ldst__granted), 64'd0);
        checkOutput("rel_wready_n1", 64'(memc__dma__write_ready), 64'd2);
        checkOutput("rel_mem_addr_n1", 64'(memc__mem__addr), 64'h80);
        checkOutput("rel_mem_we_n1", 64'(memc__mem__we), 64'd0);
        step();
        dma__memc__write_valid = 2'b00;
        checkOutput("rel_mem_addr_n2", 64'(memc__mem__addr), 64'h20);
        checkOutput("rel_mem_we_n2", 64'(memc__mem__we), 64'd1);
        step();
        checkOutput("rel_ldst_rdv", 64'(memc__ldst__read_data_valid), 64'd1);
        checkOutput("rel_ldst_rd", 64'(memc__ldst__read_data), 64'hCAFEF00D);
        checkOutput("rel_dma_rdv", 64'(memc__dma__read_data_valid), 64'd0);
        step();
        checkOutput("rel_ldst_rdv_off", 64'(memc__ldst__read_data_valid), 64'd0);

        // Reset one cycle after a DMA read accept discards the read.
        dma__memc__read_valid[0]   = 1'b1;
        dma__memc__read_address[0] = 24'h40;
        #1;
        checkOutput("rst_rready", 64'(memc__dma__read_ready), 64'd1);
        step();
        dma__memc__read_valid = 2'b00;
        reset_poweron = 1'b1;
        step();
        reset_poweron = 1'b0;
        #1;
        checkAllZero("rst_after");
        step();
        checkOutput("rst_dma_rdv_a", 64'(memc__dma__read_data_valid), 64'd0);
        step();
        checkOutput("rst_dma_rdv_b", 64'(memc__dma__read_data_valid), 64'd0);
        checkOutput("rst_ldst_rdv", 64'(memc__ldst__read_data_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
